// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRAP,
      RET,
      REDIR,
      DRAIN
   } trap_state_e;

   typedef enum logic [1:0] {
      MTVAL_ZERO,
      MTVAL_PC,
      MTVAL_ADDR,
      MTVAL_INSTR
   } mtval_sel_e;

   localparam logic [4:0] CAUSE_IADDR_MIS = 5'd0;
   localparam logic [4:0] CAUSE_ILLEGAL   = 5'd2;
   localparam logic [4:0] CAUSE_BREAK     = 5'd3;
   localparam logic [4:0] CAUSE_LOAD_MIS  = 5'd4;
   localparam logic [4:0] CAUSE_STORE_MIS = 5'd6;
   localparam logic [4:0] CAUSE_ECALL_M   = 5'd11;
   localparam logic [4:0] CAUSE_MEXT_IRQ  = 5'd11;

   localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
   localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/trap_ctrl_if.sv
// Execute-stage trap sources, CSR write-back and PC redirect bundle of the trap sequencer.
interface trap_ctrl_if #(
   parameter int unsigned XLEN = 32
);
   logic            inst_addr_misaligned;
   logic            load_misaligned;
   logic            store_misaligned;
   logic            illegal_instr;
   logic            ecall;
   logic            ebreak;
   logic            mret;
   logic            ext_irq;
   logic            mstatus_mie;
   logic            mie_meie;
   logic [XLEN-1:0] pc_exe;
   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] alu_result;
   logic [31:0]     instr_exe;
   logic [XLEN-1:0] mtvec;
   logic [XLEN-1:0] mepc_q;

   logic            csr_trap_we;
   logic            csr_mret_we;
   logic [XLEN-1:0] mepc_d;
   logic [XLEN-1:0] mcause_d;
   logic [XLEN-1:0] mtval_d;
   logic            flush;
   logic            stall;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            busy;

   modport slave (
      input  inst_addr_misaligned, load_misaligned, store_misaligned, illegal_instr,
             ecall, ebreak, mret, ext_irq, mstatus_mie, mie_meie,
             pc_exe, pc_next, alu_result, instr_exe, mtvec, mepc_q,
      output csr_trap_we, csr_mret_we, mepc_d, mcause_d, mtval_d,
             flush, stall, redirect_valid, redirect_pc, busy
   );

   modport master (
      output inst_addr_misaligned, load_misaligned, store_misaligned, illegal_instr,
             ecall, ebreak, mret, ext_irq, mstatus_mie, mie_meie,
             pc_exe, pc_next, alu_result, instr_exe, mtvec, mepc_q,
      input  csr_trap_we, csr_mret_we, mepc_d, mcause_d, mtval_d,
             flush, stall, redirect_valid, redirect_pc, busy
   );
endinterface

// File: rtl/trap_prio_enc.sv
// Fixed-priority selection among synchronous exceptions and the external interrupt.
module trap_prio_enc
   import trap_pkg::*;
(
   input  logic       inst_addr_misaligned,
   input  logic       load_misaligned,
   input  logic       store_misaligned,
   input  logic       illegal_instr,
   input  logic       ecall,
   input  logic       ebreak,
   input  logic       irq_pending,
   output logic       trap_valid,
   output logic       is_irq,
   output logic [4:0] cause,
   output mtval_sel_e mtval_sel
);

   always_comb begin
      trap_valid = 1'b1;
      is_irq     = 1'b0;
      cause      = '0;
      mtval_sel  = MTVAL_ZERO;
      if (ebreak) begin
         cause = CAUSE_BREAK;
      end else if (inst_addr_misaligned) begin
         cause     = CAUSE_IADDR_MIS;
         mtval_sel = MTVAL_PC;
      end else if (illegal_instr) begin
         cause     = CAUSE_ILLEGAL;
         mtval_sel = MTVAL_INSTR;
      end else if (ecall) begin
         cause = CAUSE_ECALL_M;
      end else if (store_misaligned) begin
         cause     = CAUSE_STORE_MIS;
         mtval_sel = MTVAL_ADDR;
      end else if (load_misaligned) begin
         cause     = CAUSE_LOAD_MIS;
         mtval_sel = MTVAL_ADDR;
      end else if (irq_pending) begin
         cause  = CAUSE_MEXT_IRQ;
         is_irq = 1'b1;
      end else begin
         trap_valid = 1'b0;
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap/mret sequencer: flush, CSR update strobe, fetch redirect, pipeline drain.
module trap_ctrl
   import trap_pkg::*;
#(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned DRAIN_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   trap_ctrl_if.slave  bus
);

   localparam int unsigned CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   trap_state_e     state;
   logic [CW-1:0]   drain_cnt;
   logic            trap_valid;
   logic            is_irq;
   logic [4:0]      cause;
   mtval_sel_e      mtval_sel;
   logic [XLEN-1:0] mtval_next;
   logic [XLEN-1:0] vec_base;

   trap_prio_enc u_prio (
      .inst_addr_misaligned (bus.inst_addr_misaligned),
      .load_misaligned      (bus.load_misaligned),
      .store_misaligned     (bus.store_misaligned),
      .illegal_instr        (bus.illegal_instr),
      .ecall                (bus.ecall),
      .ebreak               (bus.ebreak),
      .irq_pending          (bus.ext_irq & bus.mstatus_mie & bus.mie_meie),
      .trap_valid           (trap_valid),
      .is_irq               (is_irq),
      .cause                (cause),
      .mtval_sel            (mtval_sel)
   );

   always_comb begin
      mtval_next = '0;
      case (mtval_sel)
         MTVAL_PC:    mtval_next = bus.pc_exe;
         MTVAL_ADDR:  mtval_next = bus.alu_result;
         MTVAL_INSTR: mtval_next = XLEN'(bus.instr_exe);
         default:     mtval_next = '0;
      endcase
   end

   // Vectored offset only applies to interrupts; modes 10/11 fall back to direct.
   always_comb begin
      vec_base = {bus.mtvec[XLEN-1:2], 2'b00};
      if (bus.mtvec[1:0] == MTVEC_VECTORED && bus.mcause_d[XLEN-1])
         vec_base = vec_base + XLEN'({bus.mcause_d[4:0], 2'b00});
   end

   // Outputs are registered: each branch sets the values seen during the next state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state              <= IDLE;
         drain_cnt          <= '0;
         bus.csr_trap_we    <= 1'b0;
         bus.csr_mret_we    <= 1'b0;
         bus.mepc_d         <= '0;
         bus.mcause_d       <= '0;
         bus.mtval_d        <= '0;
         bus.flush          <= 1'b0;
         bus.stall          <= 1'b0;
         bus.redirect_valid <= 1'b0;
         bus.redirect_pc    <= '0;
         bus.busy           <= 1'b0;
      end else begin
         bus.csr_trap_we    <= 1'b0;
         bus.csr_mret_we    <= 1'b0;
         bus.redirect_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (trap_valid) begin
                  state           <= TRAP;
                  bus.mepc_d      <= is_irq ? bus.pc_next : bus.pc_exe;
                  bus.mcause_d    <= {is_irq, {(XLEN-6){1'b0}}, cause};
                  bus.mtval_d     <= mtval_next;
                  bus.csr_trap_we <= 1'b1;
                  bus.flush       <= 1'b1;
                  bus.stall       <= 1'b1;
                  bus.busy        <= 1'b1;
               end else if (bus.mret) begin
                  state           <= RET;
                  bus.csr_mret_we <= 1'b1;
                  bus.flush       <= 1'b1;
                  bus.stall       <= 1'b1;
                  bus.busy        <= 1'b1;
               end else begin
                  bus.flush <= 1'b0;
                  bus.stall <= 1'b0;
                  bus.busy  <= 1'b0;
               end
            end
            TRAP: begin
               state              <= REDIR;
               bus.redirect_pc    <= vec_base;
               bus.redirect_valid <= 1'b1;
            end
            RET: begin
               state              <= REDIR;
               bus.redirect_pc    <= {bus.mepc_q[XLEN-1:2], 2'b00};
               bus.redirect_valid <= 1'b1;
            end
            REDIR: begin
               state     <= DRAIN;
               drain_cnt <= CW'(DRAIN_CYCLES - 1);
            end
            DRAIN: begin
               if (drain_cnt == '0) begin
                  state     <= IDLE;
                  bus.flush <= 1'b0;
                  bus.stall <= 1'b0;
                  bus.busy  <= 1'b0;
               end else begin
                  drain_cnt <= drain_cnt - CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed-vector bench for trap_ctrl (XLEN=32, DRAIN_CYCLES=2).
module tb_trap_ctrl;
   import trap_pkg::*;

   logic clk;
   logic reset_n;
   int   vectors;
   int   miscompares;

   trap_ctrl_if #(.XLEN(32)) bus ();

   trap_ctrl #(.XLEN(32), .DRAIN_CYCLES(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.inst_addr_misaligned = 1'b0;
      bus.load_misaligned      = 1'b0;
      bus.store_misaligned     = 1'b0;
      bus.illegal_instr        = 1'b0;
      bus.ecall                = 1'b0;
      bus.ebreak               = 1'b0;
      bus.mret                 = 1'b0;
      bus.ext_irq              = 1'b0;
      bus.mstatus_mie          = 1'b0;
      bus.mie_meie             = 1'b0;
   endtask

   // Outputs are sampled on the falling edge, between active edges.
   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset_n     = 1'b0;
      clear_inputs();
      bus.pc_exe     = '0;
      bus.pc_next    = '0;
      bus.alu_result = '0;
      bus.instr_exe  = '0;
      bus.mtvec      = '0;
      bus.mepc_q     = '0;

      tick();
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_flush", 32'(bus.flush), 32'd0);
      check("reset_mcause", bus.mcause_d, 32'h0);
      check("reset_redirect_pc", bus.redirect_pc, 32'h0);

      // Load misaligned: direct vector 0x400
      reset_n = 1'b1;
      bus.load_misaligned = 1'b1;
      bus.alu_result      = 32'h1002;
      bus.pc_exe          = 32'h80;
      bus.mtvec           = 32'h400;
      tick();
      check("ld_trap_we", 32'(bus.csr_trap_we), 32'd1);
      check("ld_mcause", bus.mcause_d, 32'd4);
      check("ld_mtval", bus.mtval_d, 32'h1002);
      check("ld_mepc", bus.mepc_d, 32'h80);
      check("ld_redir_early", 32'(bus.redirect_valid), 32'd0);
      check("ld_busy1", 32'(bus.busy), 32'd1);
      clear_inputs();
      bus.ecall = 1'b1;
      tick();
      check("ld_redir_valid", 32'(bus.redirect_valid), 32'd1);
      check("ld_redir_pc", bus.redirect_pc, 32'h400);
      check("ld_trap_we_off", 32'(bus.csr_trap_we), 32'd0);
      tick();
      check("ld_busy3", 32'(bus.busy), 32'd1);
      check("ld_redir_pulse", 32'(bus.redirect_valid), 32'd0);
      tick();
      bus.ecall = 1'b0;
      check("ld_busy4", 32'(bus.busy), 32'd1);
      check("ld_stall4", 32'(bus.stall), 32'd1);
      tick();
      check("ld_idle_busy", 32'(bus.busy), 32'd0);
      check("ld_idle_flush", 32'(bus.flush), 32'd0);
      check("ld_ignored_ecall", bus.mcause_d, 32'd4);

      // Store misaligned beats an enabled interrupt; vectored mode still uses base for exceptions
      bus.store_misaligned = 1'b1;
      bus.ext_irq          = 1'b1;
      bus.mstatus_mie      = 1'b1;
      bus.mie_meie         = 1'b1;
      bus.alu_result       = 32'h2004;
      bus.pc_exe           = 32'h90;
      bus.pc_next          = 32'h94;
      bus.mtvec            = 32'h401;
      tick();
      check("st_mcause", bus.mcause_d, 32'd6);
      check("st_mtval", bus.mtval_d, 32'h2004);
      check("st_mepc", bus.mepc_d, 32'h90);
      bus.store_misaligned = 1'b0;
      bus.mstatus_mie      = 1'b0;
      tick();
      check("st_redir_pc", bus.redirect_pc, 32'h400);
      tick();
      tick();
      tick();
      check("st_idle", 32'(bus.busy), 32'd0);
      tick();
      check("irq_masked_busy", 32'(bus.busy), 32'd0);
      check("irq_masked_we", 32'(bus.csr_trap_we), 32'd0);

      // Interrupt once MIE is back on: vectored 0x400 + 4*11
      bus.mstatus_mie = 1'b1;
      bus.pc_next     = 32'h204;
      tick();
      check("irq_trap_we", 32'(bus.csr_trap_we), 32'd1);
      check("irq_mcause", bus.mcause_d, 32'h8000000B);
      check("irq_mepc", bus.mepc_d, 32'h204);
      check("irq_mtval", bus.mtval_d, 32'h0);
      clear_inputs();
      tick();
      check("irq_redir_valid", 32'(bus.redirect_valid), 32'd1);
      check("irq_redir_pc", bus.redirect_pc, 32'h42C);
      tick();
      tick();
      tick();
      check("irq_idle", 32'(bus.busy), 32'd0);

      // mret: target with low bits cleared, flush through drain
      bus.mret   = 1'b1;
      bus.mepc_q = 32'h123;
      tick();
      check("mret_we", 32'(bus.csr_mret_we), 32'd1);
      check("mret_no_trap_we", 32'(bus.csr_trap_we), 32'd0);
      check("mret_flush1", 32'(bus.flush), 32'd1);
      bus.mret = 1'b0;
      tick();
      check("mret_redir_valid", 32'(bus.redirect_valid), 32'd1);
      check("mret_redir_pc", bus.redirect_pc, 32'h120);
      check("mret_we_pulse", 32'(bus.csr_mret_we), 32'd0);
      tick();
      check("mret_flush_drain1", 32'(bus.flush), 32'd1);
      tick();
      check("mret_flush_drain2", 32'(bus.flush), 32'd1);
      tick();
      check("mret_idle_flush", 32'(bus.flush), 32'd0);
      check("mret_mcause_kept", bus.mcause_d, 32'h8000000B);

      // Illegal beats ecall; mtval is the instruction word
      bus.illegal_instr = 1'b1;
      bus.ecall         = 1'b1;
      bus.instr_exe     = 32'hDEADBEEF;
      bus.pc_exe        = 32'h1F0;
      tick();
      check("ill_mcause", bus.mcause_d, 32'd2);
      check("ill_mtval", bus.mtval_d, 32'hDEADBEEF);
      clear_inputs();
      tick();
      tick();
      tick();
      tick();
      check("ill_idle", 32'(bus.busy), 32'd0);

      // ebreak beats everything; mtvec mode 10 treated as direct
      bus.ebreak               = 1'b1;
      bus.inst_addr_misaligned = 1'b1;
      bus.illegal_instr        = 1'b1;
      bus.mret                 = 1'b1;
      bus.pc_exe               = 32'h300;
      bus.instr_exe            = 32'hFFFFFFFF;
      bus.mtvec                = 32'h502;
      tick();
      check("brk_mcause", bus.mcause_d, 32'd3);
      check("brk_mtval", bus.mtval_d, 32'h0);
      check("brk_mepc", bus.mepc_d, 32'h300);
      check("brk_no_mret_we", 32'(bus.csr_mret_we), 32'd0);
      clear_inputs();
      tick();
      check("brk_redir_pc", bus.redirect_pc, 32'h500);
      tick();
      check("brk_in_drain", 32'(bus.busy), 32'd1);

      // Asynchronous reset during drain
      #1 reset_n = 1'b0;
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_flush", 32'(bus.flush), 32'd0);
      check("rst_stall", 32'(bus.stall), 32'd0);
      check("rst_mcause", bus.mcause_d, 32'h0);
      check("rst_redir_pc", bus.redirect_pc, 32'h0);
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_rst_trap_we", 32'(bus.csr_trap_we), 32'd0);
         check("post_rst_redir", 32'(bus.redirect_valid), 32'd0);
         check("post_rst_busy", 32'(bus.busy), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
